wdt_rst_req: RTL and testbench



---
 rtl/wdt_pkg.sv | 26 ++
 rtl/wdt_prescaler.sv | 28 ++
 rtl/wdt_rst_req.sv | 158 +++++++++++++++
 tb/tb_wdt_rst_req.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog reset-request block: state encoding,
// register map and the default kick key.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIRE = 2'd2,
        ST_DONE = 2'd3
    } wdt_state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
    localparam logic [1:0] ADDR_KICK    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam logic [31:0] DEFAULT_KICK_KEY = 32'h0000_A5C3;

    // STATUS layout: count in 15:0, fired flag in 16, state in 18:17.
    function automatic logic [31:0] status_word(input logic [15:0] cnt,
                                                input logic fired,
                                                input wdt_state_t st);
        return {13'd0, st, fired, cnt};
    endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Free-running divide-by-PRESCALE tick generator with synchronous clear.
// The tick is asserted during the last count of each period.
module wdt_prescaler #(
    parameter int PRESCALE = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/wdt_rst_req.sv
// Watchdog with keyed kick register; on expiry or a bad kick it drives a
// fixed-length active-low reset request and latches a reset-surviving flag.
module wdt_rst_req
    import wdt_pkg::*;
#(
    parameter int          PRESCALE  = 25000,
    parameter int          PULSE_LEN = 16,
    parameter logic [31:0] KICK_KEY  = DEFAULT_KICK_KEY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        rst_req_n,
    output logic        wdt_fired
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    wdt_state_t    state;
    wdt_state_t    next_state;
    logic          enable;
    logic          lock;
    logic [15:0]   timeout;
    logic [15:0]   count;
    logic [PW-1:0] pulse_cnt;
    logic          bad_kick_q;
    logic          rst_req_q;
    // Power-up value only; deliberately untouched by rst so the cause survives.
    logic          fired_q = 1'b0;
    logic [31:0]   rdata;

    logic wr;
    logic cfg_wr_ok;
    logic ctrl_wr;
    logic tmo_wr;
    logic kick_wr;
    logic good_kick;
    logic bad_kick;
    logic clr_fired;
    logic pulse_last;
    logic tick;
    logic presc_clr;
    logic presc_en;

    assign wr         = stb && we;
    assign cfg_wr_ok  = wr && !lock && (state != ST_FIRE);
    assign ctrl_wr    = cfg_wr_ok && (addr == ADDR_CTRL);
    assign tmo_wr     = cfg_wr_ok && (addr == ADDR_TIMEOUT);
    assign kick_wr    = wr && (addr == ADDR_KICK) && (state == ST_RUN);
    assign good_kick  = kick_wr && (data_in == KICK_KEY);
    assign bad_kick   = kick_wr && (data_in != KICK_KEY);
    assign clr_fired  = wr && (addr == ADDR_STATUS) && data_in[16] && (state != ST_FIRE);
    assign pulse_last = (pulse_cnt == PW'(PULSE_LEN - 1));
    assign presc_clr  = ((state == ST_IDLE) && (next_state == ST_RUN)) || good_kick;
    assign presc_en   = (state == ST_RUN);

    wdt_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (presc_clr),
        .en  (presc_en),
        .tick(tick)
    );

    // A bad kick is registered first, so the pulse starts one cycle after the ack.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_wr && data_in[0]) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (bad_kick_q || (tick && (count == 16'd0) && !good_kick)) begin
                    next_state = ST_FIRE;
                end else if (ctrl_wr && !data_in[0]) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FIRE: begin
                if (pulse_last) next_state = ST_DONE;
            end
            ST_DONE: begin
                if (ctrl_wr && !data_in[0]) next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:    rdata = {30'd0, lock, enable};
            ADDR_TIMEOUT: rdata = {16'd0, timeout};
            ADDR_KICK:    rdata = '0;
            ADDR_STATUS:  rdata = status_word(count, fired_q, state);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            enable     <= 1'b0;
            lock       <= 1'b0;
            timeout    <= 16'hFFFF;
            count      <= '0;
            pulse_cnt  <= '0;
            bad_kick_q <= 1'b0;
            rst_req_q  <= 1'b1;
            ack        <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= next_state;
            ack        <= stb;
            data_out   <= (stb && !we) ? rdata : '0;
            bad_kick_q <= bad_kick;
            rst_req_q  <= (next_state != ST_FIRE);

            if (ctrl_wr) begin
                enable <= data_in[0];
                lock   <= lock | data_in[1];
            end
            if (tmo_wr) timeout <= data_in[15:0];

            // A good kick outranks a coincident tick, even one at count zero.
            if ((state == ST_IDLE) && (next_state == ST_RUN)) begin
                count <= timeout;
            end else if (state == ST_RUN) begin
                if (good_kick) begin
                    count <= timeout;
                end else if (tick && (count != 16'd0)) begin
                    count <= count - 1'b1;
                end
            end

            pulse_cnt <= (state == ST_FIRE) ? pulse_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state != ST_FIRE) && (next_state == ST_FIRE)) begin
                fired_q <= 1'b1;
            end else if (clr_fired) begin
                fired_q <= 1'b0;
            end
        end
    end

    assign rst_req_n = rst_req_q;
    assign wdt_fired = fired_q;

endmodule

// File: tb/tb_wdt_rst_req.sv
// Scoreboard bench for wdt_rst_req: an edge-indexed reference model predicts bus
// responses and the reset request; a negedge monitor compares against the DUT.
module tb_wdt_rst_req;

    localparam int          P   = 4;
    localparam int          L   = 3;
    localparam logic [31:0] KEY = 32'h0000_A5C3;
    localparam logic [31:0] BAD = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic        rst_req_n;
    logic        wdt_fired;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    typedef struct {
        int          edge_no;
        bit          is_read;
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: time is measured in clock edges; count is derived from
    // the last reload edge instead of being stepped.
    int  m_state       = 0;
    bit  m_enable      = 1'b0;
    bit  m_lock        = 1'b0;
    bit  m_fired       = 1'b0;
    int  m_timeout     = 16'hFFFF;
    int  m_reload_edge = 0;
    int  m_reload_val  = 0;
    int  m_frozen      = 0;
    int  m_bad_edge    = -100;
    int  m_fire_edge   = 0;
    bit  m_rstn        = 1'b1;

    wdt_rst_req #(
        .PRESCALE (P),
        .PULSE_LEN(L),
        .KICK_KEY (KEY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .rst_req_n(rst_req_n),
        .wdt_fired(wdt_fired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish, required finish");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic int run_count(input int e);
        int k;
        k = (e - m_reload_edge) / P;
        return (k >= m_reload_val) ? 0 : m_reload_val - k;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        int          e;
        int          cnt_before;
        bit          wr;
        bit          cfg_ok;
        bit          good;
        bit          bad;
        bit          fire;
        logic [31:0] rd;
        exp_t        x;
        e = cyc;
        if (rst) begin
            m_state    = 0;
            m_enable   = 1'b0;
            m_lock     = 1'b0;
            m_timeout  = 16'hFFFF;
            m_frozen   = 0;
            m_bad_edge = -100;
            m_rstn     = 1'b1;
        end else begin
            cnt_before = (m_state == 1) ? run_count(e - 1) : m_frozen;
            if (stb) begin
                case (addr)
                    2'd0:    rd = {30'd0, m_lock, m_enable};
                    2'd1:    rd = 32'(m_timeout);
                    2'd2:    rd = 32'd0;
                    default: rd = {13'd0, 2'(m_state), m_fired, 16'(cnt_before)};
                endcase
                x.edge_no = e;
                x.is_read = !we;
                x.addr    = int'(addr);
                x.data    = rd;
                exp_q.push_back(x);
            end
            wr     = stb && we;
            cfg_ok = wr && !m_lock && (m_state != 2);
            good   = wr && (m_state == 1) && (addr == 2'd2) && (data_in == KEY);
            bad    = wr && (m_state == 1) && (addr == 2'd2) && (data_in != KEY);
            fire   = 1'b0;
            if (m_state == 1) begin
                fire = (m_bad_edge == e - 1) ||
                       (!good && (e == m_reload_edge + P * (m_reload_val + 1)));
                if (good) begin
                    m_reload_edge = e;
                    m_reload_val  = m_timeout;
                end
            end
            if (wr && (m_state != 2) && (addr == 2'd3) && data_in[16]) m_fired = 1'b0;
            case (m_state)
                0: begin
                    if (cfg_ok && (addr == 2'd0) && data_in[0]) begin
                        m_state       = 1;
                        m_reload_edge = e;
                        m_reload_val  = m_timeout;
                    end
                end
                1: begin
                    if (fire) begin
                        m_frozen    = run_count(e);
                        m_state     = 2;
                        m_fire_edge = e;
                        m_fired     = 1'b1;
                    end else if (cfg_ok && (addr == 2'd0) && !data_in[0]) begin
                        m_frozen = run_count(e);
                        m_state  = 0;
                    end
                    if (bad) m_bad_edge = e;
                end
                2: begin
                    if (e == m_fire_edge + L) m_state = 3;
                end
                default: begin
                    if (cfg_ok && (addr == 2'd0) && !data_in[0]) m_state = 0;
                end
            endcase
            if (cfg_ok && (addr == 2'd0)) begin
                m_enable = data_in[0];
                m_lock   = m_lock | data_in[1];
            end
            if (cfg_ok && (addr == 2'd1)) m_timeout = int'(data_in[15:0]);
            m_rstn = (m_state != 2);
        end
        cyc++;
    end

    always @(negedge clk) begin : monitor
        exp_t x;
        if (cyc > 0) begin
            check_output("rst_req_n", 32'(rst_req_n), 32'(m_rstn));
            check_output("wdt_fired", 32'(wdt_fired), 32'(m_fired));
            if (ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL ack_unexpected: got ack=1, expected ack=0");
                end else begin
                    x = exp_q.pop_front();
                    check_output("ack_edge", 32'(cyc - 1), 32'(x.edge_no));
                    if (x.is_read) check_output($sformatf("read_addr%0d", x.addr), data_out, x.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_no <= cyc - 1) begin
                x = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("[TB] FAIL ack_missing: got ack=0, expected ack=1 for edge %0d", x.edge_no);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_write(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic apply_read(input logic [1:0] a);
        stb = 1'b1; we = 1'b0; addr = a; data_in = $urandom;
        @(posedge clk);
        #1;
        stb = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic wait_low(input int max_edges, output int k);
        k = -1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk);
            #1;
            if (rst_req_n === 1'b0) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic measure_low(output int n);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rst_req_n === 1'b0) n++;
            else return;
        end
    endtask

    initial begin : stimulus
        int k;
        int n;
        int seen_low;
        logic [1:0]  a;
        logic [31:0] d;
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
        idle(3);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) apply_read(2'(i));
        idle(2);

        apply_write(2'd1, 32'd2);
        apply_write(2'd0, 32'd1);
        wait_low(40, k);
        check_output("timeout_fire_latency", 32'(k), 32'd12);
        measure_low(n);
        check_output("timeout_pulse_len", 32'(n), 32'(L));
        idle(1);
        apply_read(2'd3);
        apply_write(2'd0, 32'd0);

        apply_write(2'd0, 32'd1);
        repeat (12) begin
            apply_write(2'd2, KEY);
            idle(3);
            apply_read(2'd3);
            idle(3);
        end
        apply_write(2'd0, 32'd0);

        apply_write(2'd1, 32'd100);
        apply_write(2'd0, 32'd1);
        idle(2);
        apply_write(2'd2, BAD);
        wait_low(10, k);
        check_output("bad_kick_latency", 32'(k), 32'd1);
        measure_low(n);
        check_output("bad_kick_pulse_len", 32'(n), 32'(L));
        idle(2);
        apply_read(2'd3);
        apply_write(2'd0, 32'd0);

        seen_low = 0;
        apply_write(2'd2, BAD);
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rst_req_n === 1'b0) seen_low = 1;
        end
        check_output("idle_kick_no_pulse", 32'(seen_low), 32'd0);

        apply_write(2'd1, 32'd50);
        apply_write(2'd0, 32'd2);
        apply_write(2'd0, 32'd0);
        apply_write(2'd0, 32'd1);
        apply_write(2'd1, 32'd5);
        apply_read(2'd0);
        apply_read(2'd1);
        apply_reset(2);
        apply_read(2'd0);
        apply_read(2'd3);
        apply_write(2'd3, 32'h0001_0000);
        apply_read(2'd3);
        check_output("fired_cleared", 32'(wdt_fired), 32'd0);

        apply_write(2'd1, 32'd0);
        apply_write(2'd0, 32'd1);
        wait_low(20, k);
        check_output("zero_timeout_latency", 32'(k), 32'(P));
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("rst_mid_fire_release", 32'(rst_req_n), 32'd1);
        apply_read(2'd3);

        apply_write(2'd1, 32'd1);
        apply_write(2'd0, 32'd1);
        idle(7);
        apply_write(2'd2, KEY);
        apply_read(2'd3);
        check_output("kick_at_zero_no_fire", 32'(rst_req_n), 32'd1);
        apply_write(2'd0, 32'd0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                apply_reset($urandom_range(1, 2));
            end else begin
                a = 2'($urandom_range(0, 3));
                case (a)
                    2'd0:    d = {30'd0, 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) != 0)};
                    2'd1:    d = 32'($urandom_range(0, 5));
                    2'd2:    d = ($urandom_range(0, 3) != 0) ? KEY : $urandom;
                    default: d = $urandom;
                endcase
                if ($urandom_range(0, 1) == 1) apply_write(a, d);
                else apply_read(a);
            end
            idle($urandom_range(0, 3));
        end

        idle(4);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
